// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period/high time of a divided clock, tracks lock and latches faults
module div_clk_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 5,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_clk,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_cause
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MAX  = '1;
  localparam logic [CNT_W-1:0] EXP  = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOLV = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LCV  = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]    LCM1 = MW'(LOCK_COUNT - 1);

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] pcnt, hcnt, diff, pcnt_inc, hcnt_inc;
  logic [MW-1:0]    match_cnt;
  logic             rise, take, in_tol, timeout, bad, new_fault;

  assign rise      = s2 & ~s3;
  assign take      = (state == MEASURE) & rise;
  assign pcnt_inc  = (pcnt == MAX) ? pcnt : pcnt + CNT_W'(1);
  assign hcnt_inc  = (hcnt == MAX) ? hcnt : hcnt + CNT_W'(1);
  assign diff      = (pcnt >= EXP) ? pcnt - EXP : EXP - pcnt;
  assign in_tol    = (pcnt != MAX) && (diff <= TOLV);
  assign timeout   = (state != IDLE) && !rise && (pcnt == TMO);
  assign bad       = take & ~in_tol;
  assign new_fault = enable & (bad | timeout);

  // two-flop synchronizer plus delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= div_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // monitor FSM with period/high counters, measurement capture and lock tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pcnt       <= '0;
      hcnt       <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= enable & take;
      if (!enable) begin
        state     <= IDLE;
        pcnt      <= '0;
        hcnt      <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else if (state == IDLE) begin
        state <= ARM;
        pcnt  <= '0;
        hcnt  <= '0;
      end else if (timeout) begin
        state     <= ARM;
        pcnt      <= '0;
        hcnt      <= s2 ? hcnt_inc : hcnt;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        pcnt <= rise ? CNT_W'(1) : pcnt_inc;
        hcnt <= rise ? CNT_W'(1) : (s2 ? hcnt_inc : hcnt);
        if (rise) state <= MEASURE;
        if (take) begin
          period    <= pcnt;
          high_time <= hcnt;
          match_cnt <= in_tol ? ((match_cnt == LCV) ? match_cnt : match_cnt + MW'(1)) : '0;
          locked    <= in_tol && (match_cnt >= LCM1);
        end
      end
    end
  end

  // sticky fault; a new fault in the same cycle as a clear wins and records its cause
  always_ff @(posedge clk) begin
    if (reset) begin
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else if (new_fault) begin
      fault <= 1'b1;
      if (clear_fault || fault_cause == 2'b00) fault_cause <= bad ? 2'b01 : 2'b10;
    end else if (clear_fault) begin
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end
  end
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: randomized divided-clock stimulus checked against a timestamp-based reference model
module tb_div_clk_monitor;
  localparam int TIMEOUT = 16;
  localparam int EXP_P   = 5;
  localparam int TOL     = 0;
  localparam int LOCKN   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       div_clk = 1'b0;
  logic       clear_fault = 1'b0;
  logic [7:0] period, high_time;
  logic       meas_valid, locked, fault;
  logic [1:0] fault_cause;

  int n_checks = 0;
  int n_errors = 0;

  div_clk_monitor dut (
    .clk(clk), .reset(reset), .enable(enable), .div_clk(div_clk), .clear_fault(clear_fault),
    .period(period), .high_time(high_time), .meas_valid(meas_valid), .locked(locked),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: samples recorded per edge, measurements from edge timestamps
  bit d [0:19999];
  int n = 3;
  int mode = 0;
  int anchor = 0;
  int last = 0;
  int match = 0;
  int m_period = 0, m_high = 0, m_mv = 0, m_lock = 0, m_fault = 0, m_cause = 0;
  bit started = 0;

  always @(posedge clk) begin
    int pc, hs, nc;
    bit r, nf;
    d[n] = reset ? 1'b0 : div_clk;
    if (reset) begin
      d[n-1] = 0; d[n-2] = 0;
      mode = 0; match = 0;
      m_period = 0; m_high = 0; m_mv = 0; m_lock = 0; m_fault = 0; m_cause = 0;
    end else begin
      r = d[n-2] && !d[n-3];
      m_mv = 0; nf = 0; nc = 0;
      if (!enable) begin
        mode = 0; match = 0; m_lock = 0;
      end else if (mode == 0) begin
        mode = 1; anchor = n + 1;
      end else begin
        pc = n - anchor;
        if (pc > 255) pc = 255;
        if (!r && pc == TIMEOUT) begin
          nf = 1; nc = 2; mode = 1; anchor = n + 1; match = 0; m_lock = 0;
        end else if (r) begin
          if (mode == 2) begin
            hs = 0;
            for (int m = last; m < n; m++) hs += d[m-2];
            m_mv = 1; m_period = pc; m_high = hs;
            if (pc != 255 && (pc - EXP_P <= TOL) && (EXP_P - pc <= TOL)) begin
              match = (match < LOCKN) ? match + 1 : LOCKN;
              m_lock = (match == LOCKN);
            end else begin
              match = 0; m_lock = 0; nf = 1; nc = 1;
            end
          end
          mode = 2; last = n; anchor = n;
        end
      end
      if (nf) begin
        if (clear_fault || m_cause == 0) m_cause = nc;
        m_fault = 1;
      end else if (clear_fault) begin
        m_fault = 0; m_cause = 0;
      end
    end
    n++;
    started = 1;
  end

  // compare every output each cycle, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("period", 32'(period), 32'(m_period));
      check("high_time", 32'(high_time), 32'(m_high));
      check("meas_valid", 32'(meas_valid), 32'(m_mv));
      check("locked", 32'(locked), 32'(m_lock));
      check("fault", 32'(fault), 32'(m_fault));
      check("fault_cause", 32'(fault_cause), 32'(m_cause));
    end
  end

  bit chaos = 0;
  int dis = 0;

  task automatic tick(input logic v);
    div_clk = v;
    reset = 1'b0;
    clear_fault = 1'b0;
    if (chaos) begin
      if ($urandom_range(0, 39) == 0) clear_fault = 1'b1;
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if (dis > 0) begin
        enable = 1'b0; dis--;
      end else if ($urandom_range(0, 99) == 0) begin
        enable = 1'b0; dis = $urandom_range(0, 5);
      end else enable = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic per(input int p, input int h);
    for (int c = 0; c < p; c++) tick(c < h);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) per(5, 2);
    per(7, 3);
    for (int i = 0; i < 5; i++) per(5, 2);
    per(20, 0);
    for (int i = 0; i < 6; i++) per(5, 2);
    per(3, 1);
    for (int i = 0; i < 6; i++) per(5, 2);
    chaos = 1;
    for (int i = 0; i < 350; i++) begin
      case ($urandom_range(0, 19))
        0: per(7, 3);
        1: per(3, 1);
        2: per($urandom_range(14, 22), 0);
        3: per(6, 3);
        default: per(5, 2);
      endcase
    end
    chaos = 0;
    reset = 1'b0; enable = 1'b1; clear_fault = 1'b0;
    for (int i = 0; i < 6; i++) per(5, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Downstream checker for the odd-ratio clock dividers (e.g. the divide-by-5, 50%-duty divider). It samples the divided clock in the source `clk` domain and measures period and high time in `clk` cycles. It declares lock after a run of in-tolerance periods and raises a sticky fault on an out-of-range period or a missing edge. Its status feeds the clock-control/status register block.

## Interface
- `CNT_W`, default 8: width of the period and high-time counters; they saturate at 2^CNT_W−1.
- `EXP_PERIOD`, default 5: expected divided-clock period, in `clk` cycles.
- `TOL`, default 0: allowed |period − EXP_PERIOD|, in cycles.
- `LOCK_COUNT`, default 4: consecutive in-tolerance periods required to assert `locked`.
- `TIMEOUT`, default 16: number of cycles without a rising edge that counts as a missing clock. Must satisfy TIMEOUT > EXP_PERIOD + TOL.

Ports:
- `clk` in 1: source clock. All logic is on posedge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: monitor enable. When low, the monitor idles.
- `div_clk` in 1: divided clock under test. It is treated as asynchronous data.
- `clear_fault` in 1: single-cycle pulse that clears `fault` and `fault_cause`.
- `period` out CNT_W: last measured period.
- `high_time` out CNT_W: number of cycles the synchronized `div_clk` was sampled high during the last measured period.
- `meas_valid` out 1: one-cycle pulse when `period`/`high_time` update.
- `locked` out 1: lock status.
- `fault` out 1: sticky fault flag.
- `fault_cause` out 2: 01 = period out of tolerance, 10 = timeout. Holds the first cause since the last clear.

## Operation
- **Synchronizer:** two flops, `s1` → `s2`, then a delay flop `s3`. `rise = s2 & ~s3`.
- **States:**
  - IDLE: `enable` = 0.
  - ARM: waiting for the first rise.
  - MEASURE.
- **Transitions:**
  - IDLE → ARM when `enable` = 1.
  - ARM → MEASURE on `rise`.
  - MEASURE → ARM on timeout.
  - Any state → IDLE when `enable` = 0.
- **Period counter `pcnt`:**
  - Loads 1 on `rise`.
  - Otherwise increments, saturating.
  - On a `rise` in MEASURE: `period <= pcnt`.
- **High counter `hcnt`:**
  - On `rise`, loads 1. This is correct because `s2` = 1 on every `rise` cycle.
  - Otherwise increments when `s2` = 1, saturating.
  - On a `rise` in MEASURE: `high_time <= hcnt`.
- **`meas_valid`:** high for the cycle after each `rise` taken in MEASURE. The first rise in ARM produces no measurement.
- **Tolerance check** (on each measurement):
  - In tolerance: `match_cnt` increments, saturating at LOCK_COUNT. `locked` = 1 when `match_cnt` == LOCK_COUNT.
  - Out of tolerance: `match_cnt` <= 0, `locked` <= 0, `fault` <= 1, `fault_cause` <= 01 if it was 00.
- **Timeout:** in ARM or MEASURE, `pcnt` reaches TIMEOUT with no `rise`. Then:
  - `fault` <= 1, and `fault_cause` <= 10 if it was 00.
  - `locked` <= 0, `match_cnt` <= 0.
  - Return to ARM with `pcnt` <= 0.
- **IDLE:** `pcnt`, `hcnt` and `match_cnt` are cleared and `locked` = 0. `fault`, `fault_cause`, `period` and `high_time` are retained.
- **Fault clearing:** `clear_fault` clears `fault` and `fault_cause` to 0. If a new fault occurs in the same cycle, the new fault wins and its cause is recorded.
- **Counter saturation:** saturated counters stay at max. A saturated period is always out of tolerance.

## Timing
- **Reset values:** `period` = 0, `high_time` = 0, `meas_valid` = 0, `locked` = 0, `fault` = 0, `fault_cause` = 00. State = IDLE, all counters 0, sync flops 0.
- **Latency:** `div_clk` first sampled high at posedge k. Then `s2` = 1 after k+1, `rise` is true during cycle k+1 → k+2, registers update at k+2, and `meas_valid` is high in the cycle after posedge k+2.
- **`locked` assertion:** rises in the same cycle as the `meas_valid` of the LOCK_COUNT-th consecutive good period.
- **`fault` assertion:** rises in the same cycle as the failing `meas_valid`, or in the cycle after the timeout threshold is hit.
- **Reset mid-measurement:** returns everything to reset values on the next posedge. The first post-reset rise is ARM only.
- **Edge of `enable`:** an `enable` drop on the same cycle as `rise` drops the measurement.

## Test plan
- Reset, enable, drive from a divide-by-5 divider → first `meas_valid` shows `period` = 5, `high_time` = 2. `locked` = 1 at the 4th measurement, `fault` stays 0.
- Locked, then one period stretched to 7 (TOL = 0) → `meas_valid` with `period` = 7, `locked` = 0, `fault` = 1, `fault_cause` = 01. Four more good periods → `locked` = 1 again, `fault` still 1.
- Hold `div_clk` low while locked → `fault` = 1, `fault_cause` = 10 exactly 16 cycles after the last `rise`. Restart the clock → first rise gives no `meas_valid`, the next gives `period` = 5.
- Pulse `clear_fault` in the same cycle as a bad period of 3 → `fault` = 1, `fault_cause` = 01. Pulse `clear_fault` alone later → `fault` = 0, `fault_cause` = 00.
- Deassert `enable` mid-period, then re-enable → `locked` = 0 while disabled, no `meas_valid` until the second rise, `period` holds its old value meanwhile.
- Assert `reset` for 1 cycle mid-lock → all outputs return to reset values on the next cycle. Lock is reacquired after 1 arming rise plus 4 good periods.
